mux_nx1_pipe: RTL
=================

# mux_nx1_pipe

Parametrised, pipelined N-to-1 multiplexer for `2^SEL_W` channels of `WIDTH` bits each. It is built as a binary tree of 2:1 stages with one register level per tree level. The block adds a valid-qualified data path and a round-robin scan mode that steps the selection internally. It replaces hand-chained 2:1 muxes wherever a wide or deep channel select must meet timing and carry a sample-valid alongside the data.

## Interface

**Parameters**

- `WIDTH`, default 1: bits per channel.
- `SEL_W`, default 2: select width. `N = 2^SEL_W` channels. Legal range 1..6.

**Ports**

- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `i`  input  N*WIDTH: channel k occupies `i[k*WIDTH +: WIDTH]`.
- `sel`  input  SEL_W: external channel select, used when `scan`=0.
- `scan`  input  1: 1 = internal round-robin counter drives selection; 0 = `sel` drives it.
- `in_valid`  input  1: sample present on `i` this cycle.
- `y`  output  WIDTH: selected channel data.
- `y_sel`  output  SEL_W: channel index that produced `y`.
- `out_valid`  output  1: `y`/`y_sel` updated this cycle with a new sample.

## Operation

- Effective select is `esel = scan ? cnt : sel`, evaluated combinationally in the sampling cycle.
- The tree has SEL_W levels. Level 0 registers N/2 pairwise picks of `i` using `esel[0]`. Pair p yields `i[2p+1]` when the bit is 1, otherwise `i[2p]`. Level L (L ≥ 1) picks between entries of level L-1 using `esel[L]`. The final level holds one entry, which drives `y`.
- `esel` bits above the current level travel with the data through per-level select registers. The full `esel` also travels to `y_sel`.
- A valid bit shifts through SEL_W stages every cycle unconditionally.
- Data and select registers at a level load only when the valid arriving at that level is 1; otherwise they hold. As a result, `y`/`y_sel` hold the last valid result through bubbles.
- Scan counter `cnt` (SEL_W bits):
  - Increments by 1 on each cycle with `scan`=1 and `in_valid`=1.
  - Wraps N-1 → 0.
  - Holds when `scan`=0 or `in_valid`=0; it is not cleared on mode change.
- A sample taken with `scan`=1 uses the `cnt` value before that cycle's increment.
- No backpressure. A new sample is accepted every cycle.

## Timing

- Reset (async assert, any time): all pipeline registers, `cnt`, `y`, `y_sel` and `out_valid` are forced to 0 immediately. In-flight samples are discarded and none emerges after release.
- After reset release, the first sample is accepted on the first rising edge that sees `in_valid`=1.
- Latency: a sample accepted at edge t appears on `y`/`y_sel` with `out_valid`=1 after edge t+SEL_W-1, i.e. SEL_W register stages. SEL_W=1 gives 1 cycle.
- Throughput: 1 sample per cycle. Back-to-back samples with different `sel` emerge back-to-back and in order.
- `out_valid` is high for exactly one cycle per accepted sample.
- Changing `sel` or `scan` affects only the sample taken in that same cycle. Samples already in flight are unaffected.
- Wrap-around: in scan mode with continuous valid, `y_sel` sequence is 0,1,…,N-1,0,…

## Test plan

- WIDTH=1, SEL_W=2, `i`=4'b1010, `scan`=0, `sel`=00,01,10,11 on consecutive cycles with `in_valid`=1 → starting 2 cycles after the first sample, `y`=0,1,0,1 and `y_sel`=0,1,2,3 with `out_valid` high for 4 cycles.
- Same `i`, `scan`=1, `in_valid`=1 for 6 cycles → `y_sel`=0,1,2,3,0,1, `y`=0,1,0,1,0,1, and `cnt`=2 afterward.
- `in_valid` pattern 1,0,0,1 with `sel`=3 then `sel`=0 → `out_valid` pattern 1,0,0,1 (delayed 2 cycles), and `y`=1 holds through the gap until the second result 0.
- WIDTH=8, SEL_W=3, channel k = 8'hA0+k, random `sel` each cycle → `y`=8'hA0+sel and `y_sel`=sel exactly 3 cycles later, no drops.
- Assert `rst` mid-cycle with 2 samples in flight → `y`, `y_sel`, `out_valid` go to 0 immediately, no `out_valid` pulse after release, and `cnt` restarts at 0.
- SEL_W=1, `i`={4'h5,4'h3}, toggle `sel` every cycle → `y`=3,5,3,5 with 1-cycle latency.

Source files
------------

// File: rtl/mux_nx1_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mux_nx1_pipe
//  Purpose  : Pipelined N-to-1 multiplexer (N = 2**SEL_W channels of WIDTH
//             bits). Binary tree of 2:1 stages, one register level per tree
//             level, with a valid-qualified data path and an optional
//             internal round-robin select counter (scan mode).
//  Ports    : clk       - rising-edge clock
//             rst       - asynchronous active-high reset
//             i         - N*WIDTH channel bus, channel k at i[k*WIDTH +: WIDTH]
//             sel       - external channel select (scan = 0)
//             scan      - 1: internal counter selects, 0: sel selects
//             in_valid  - sample present on i this cycle
//             y         - selected channel data
//             y_sel     - channel index that produced y
//             out_valid - one-cycle pulse per emerging sample
//  Revision : 1.0 - initial release
// ============================================================================
module mux_nx1_pipe #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(1<<SEL_W)*WIDTH-1:0]   i,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          scan,
  input  logic                          in_valid,
  output logic [WIDTH-1:0]              y,
  output logic [SEL_W-1:0]              y_sel,
  output logic                          out_valid
);

  localparam int N     = 1 << SEL_W;
  localparam int NODES = N - 1;

  logic [SEL_W-1:0]           cnt_q;
  logic [SEL_W-1:0]           cnt_d;
  logic [SEL_W-1:0]           esel;

  // Registered tree nodes, level 0 first: level l occupies N>>(l+1) entries
  // starting at entry N - (N>>l).
  logic [NODES*WIDTH-1:0]     node_q;
  logic [NODES*WIDTH-1:0]     node_d;

  // Per-level select and valid registers.
  logic [SEL_W-1:0]           s_q [SEL_W];
  logic [SEL_W-1:0]           v_q;

  // Chains seen by each level: index 0 is the sampling cycle, index l+1 is
  // the output of level l, index SEL_W is the pipeline output.
  logic [SEL_W-1:0]           s_chain [SEL_W+1];
  logic [SEL_W:0]             v_chain;

  // Whole tree as one heap-ordered vector: the N leaves (input channels)
  // followed by the registered nodes. Level l reads its pairs starting at
  // entry 2N - (2N>>l) and the root sits at entry 2N-2.
  logic [(N+NODES)*WIDTH-1:0] tree;

  assign esel    = scan ? cnt_q : sel;
  assign cnt_d   = (scan && in_valid) ? cnt_q + 1'b1 : cnt_q;
  assign v_chain = {v_q, in_valid};
  assign tree    = {node_q, i};

  always_comb begin
    s_chain[0] = esel;
    for (int l = 0; l < SEL_W; l++) begin
      s_chain[l+1] = s_q[l];
    end
  end

  // Each level loads only when the valid arriving at it is set, so the
  // output holds the last result through bubbles.
  always_comb begin
    node_d = node_q;
    for (int l = 0; l < SEL_W; l++) begin
      for (int p = 0; p < N/2; p++) begin
        if ((p < (N >> (l+1))) && v_chain[l]) begin
          node_d[(N - (N >> l) + p)*WIDTH +: WIDTH] =
            s_chain[l][l] ? tree[((2*N) - ((2*N) >> l) + 2*p + 1)*WIDTH +: WIDTH]
                          : tree[((2*N) - ((2*N) >> l) + 2*p)*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      node_q <= '0;
      v_q    <= '0;
      for (int l = 0; l < SEL_W; l++) begin
        s_q[l] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      node_q <= node_d;
      v_q    <= v_chain[SEL_W-1:0];
      for (int l = 0; l < SEL_W; l++) begin
        if (v_chain[l]) begin
          s_q[l] <= s_chain[l];
        end
      end
    end
  end

  assign y         = tree[(2*N - 2)*WIDTH +: WIDTH];
  assign y_sel     = s_chain[SEL_W];
  assign out_valid = v_chain[SEL_W];

endmodule
`default_nettype wire
